rev_dabbler_8bit: RTL and testbench
===================================

REV_DABBLER_8BIT -- requirements
Module: rev_dabbler_8bit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port in_valid, input, 1 bit: bcd_in is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts bcd_in this cycle.
REQ-005 SHALL have port bcd_in, input, 12 bits: packed BCD digits; [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 SHALL have port out_valid, output, 1 bit: bin_out and err are valid.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts the result this cycle.
REQ-008 SHALL have port bin_out, output, 8 bits: binary equivalent of the accepted BCD value.
REQ-009 SHALL have port err, output, 1 bit: accepted value was an illegal digit or exceeded 255.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 IDLE SHALL drive in_ready=1; every other state SHALL drive in_ready=0.
REQ-012 Input accept SHALL occur when in_valid&&in_ready; on accept: load a 20-bit work register {bcd(12), bin(8)} = {bcd_in, 8'h00}; clear iteration counter; go to SHIFT.
REQ-013 On accept, a sticky digit-error flag SHALL latch 1 if any bcd_in nibble > 9, else 0.
REQ-014 Each SHIFT cycle SHALL shift the work register right by 1 (bcd[0] enters bin[7]; 0 enters bcd[11]), then subtract 3 from each shifted BCD nibble >= 8, and register the result.
REQ-015 The 3-bit iteration counter SHALL increment each SHIFT cycle; after the 8th SHIFT cycle, the FSM SHALL go to DONE.
REQ-016 Latency: out_valid SHALL assert exactly 9 cycles after the accept edge (accept edge + 8 SHIFT cycles).
REQ-017 In DONE: out_valid=1; bin_out = work bin field; err = digit-error flag OR (residual bcd field != 0), the latter indicating an overflow for values 256..999.
REQ-018 bin_out and err SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-019 When out_valid&&out_ready, the FSM SHALL go to IDLE on the next edge; no input SHALL be accepted in that same cycle.
REQ-020 in_valid asserted outside IDLE SHALL be ignored, with no effect on state or data.
REQ-021 Outside DONE, out_valid SHALL be 0; bin_out and err SHALL be 0.
REQ-022 Peak throughput SHALL be one conversion per 10 cycles.

Reset
REQ-023 When rst=1 at a clock edge, state SHALL be IDLE, and the work register, counter and error flag SHALL be 0.
REQ-024 Reset values of outputs: in_ready=1, out_valid=0, bin_out=0, err=0.
REQ-025 rst SHALL override all activity, including during SHIFT or DONE; any in-flight conversion SHALL be discarded with no output.

Structure
REQ-026 Package dabbler_pkg SHALL hold the state encoding (IDLE/SHIFT/DONE) and the constants N_DIGITS=3, BIN_W=8, N_ITER=8, CORR=3, CORR_THRESH=8.
REQ-027 The per-digit correction SHALL be a sub-module dabble_sub3: 4-bit in, 4-bit out, out = in>=8 ? in-3 : in; it SHALL be instantiated three times.

Verification
REQ-028 Stimulus: accept bcd_in=12'h255, out_ready=1 -> out_valid asserts 9 cycles later with bin_out=8'hFF, err=0.
REQ-029 Stimulus: 12'h128 -> bin_out=8'h80, err=0; 12'h000 -> bin_out=8'h00, err=0; 12'h099 -> bin_out=8'h63, err=0.
REQ-030 Stimulus: 12'h256 -> err=1 (overflow); 12'h2A0 -> err=1 (illegal digit).
REQ-031 Stimulus: 12'h042 with out_ready=0 held for 5 cycles after out_valid -> bin_out=8'h2A holds stable; in_ready=0 throughout; IDLE is re-entered 1 cycle after out_ready=1.
REQ-032 Stimulus: rst pulsed during the 4th SHIFT cycle -> next cycle in_ready=1, out_valid=0; no result is emitted; a following 12'h010 converts to 8'h0A.
REQ-033 Stimulus: in_valid held high during SHIFT with changing bcd_in -> result reflects only the originally accepted value.

Source files
------------

// File: rtl/dabbler_pkg.sv
// Shared types and constants for the reverse double-dabble BCD-to-binary converter.
// Holds the FSM encoding, datapath sizing and the BCD digit legality check.
package dabbler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int N_DIGITS    = 3;
    localparam int BIN_W       = 8;
    localparam int N_ITER      = 8;
    localparam int CORR        = 3;
    localparam int CORR_THRESH = 8;
    localparam int BCD_W       = N_DIGITS * 4;
    localparam int WORK_W      = BCD_W + BIN_W;

    // True when any packed BCD nibble holds a value above 9.
    function automatic logic bcd_illegal(input logic [BCD_W-1:0] value);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/dabble_sub3.sv
// Per-digit correction after a right shift: a nibble of 8 or more absorbed a
// half-ten (5) from the digit above as an 8, so 3 is removed to restore BCD.
module dabble_sub3
    import dabbler_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Conditional subtract-3 correction.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'(CORR_THRESH)) begin
            digit_out = digit_in - 4'(CORR);
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/rev_dabbler_8bit.sv
// Three-digit BCD to 8-bit binary converter using the reverse double-dabble
// shift/correct algorithm, with valid/ready handshakes on both sides.
module rev_dabbler_8bit
    import dabbler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] bcd_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  bin_out,
    output logic        err
);

    state_e              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                derr_q, derr_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                err_q, err_d;

    logic [WORK_W-1:0]   shifted_s;
    logic [BCD_W-1:0]    digits_corr_s;
    logic [WORK_W-1:0]   work_step_s;
    logic                accept_s;

    assign shifted_s   = {1'b0, work_q[WORK_W-1:1]};
    assign work_step_s = {digits_corr_s, shifted_s[BIN_W-1:0]};
    assign accept_s    = in_valid && in_ready_q;

    genvar g;
    for (g = 0; g < N_DIGITS; g++) begin : g_digit
        dabble_sub3 u_sub3 (
            .digit_in  (shifted_s[BIN_W + 4*g +: 4]),
            .digit_out (digits_corr_s[4*g +: 4])
        );
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        derr_d  = derr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                    work_d  = {bcd_in, 8'h00};
                    cnt_d   = 3'd0;
                    derr_d  = bcd_illegal(bcd_in);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = work_step_s;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'(N_ITER - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // Release back to IDLE only; a new accept needs in_ready, which is low here.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                work_d  = '0;
                cnt_d   = 3'd0;
                derr_d  = 1'b0;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        if (out_valid_d) begin
            bin_d = work_d[BIN_W-1:0];
            err_d = derr_d || (work_d[WORK_W-1:BIN_W] != 12'h000);
        end else begin
            bin_d = 8'h00;
            err_d = 1'b0;
        end
    end

    // State, datapath and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            cnt_q       <= 3'd0;
            derr_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bin_q       <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            derr_q      <= derr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            bin_q       <= bin_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rev_dabbler_8bit.sv
// Self-checking bench for rev_dabbler_8bit: directed cases plus random BCD values
// compared against a decimal-arithmetic reference model.
module tb_rev_dabbler_8bit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  bin_out;
    logic        err;

    int total_checks;
    int passed_checks;
    int failed_checks;

    rev_dabbler_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else begin
            failed_checks++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits; error on illegal digit or value above 255.
    task automatic ref_model(input logic [11:0] b, output logic illegal,
                             output logic [7:0] bin, output logic e);
        int h, t, u, v;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        v = h * 100 + t * 10 + u;
        illegal = (h > 9) || (t > 9) || (u > 9);
        e = illegal || (v > 255);
        bin = 8'(v % 256);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion; hold = cycles of out_ready=0 once the result is up,
    // noisy = keep in_valid high with changing bcd_in while busy.
    task automatic run_conv(input logic [11:0] bcd, input int hold, input bit noisy);
        logic       ill, exp_err;
        logic [7:0] exp_bin;
        logic [7:0] first_bin;
        logic       first_err;
        int         k;
        ref_model(bcd, ill, exp_bin, exp_err);
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        chk("in_ready_before_accept", 16'(in_ready), 16'd1);
        in_valid  = 1'b1;
        bcd_in    = bcd;
        out_ready = 1'b0;
        tick();
        if (noisy) begin
            bcd_in = 12'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        chk("in_ready_busy", 16'(in_ready), 16'd0);
        // Result is expected right after the 8th SHIFT edge following the accept edge.
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
            if (noisy) bcd_in = 12'($urandom);
        end
        in_valid = 1'b0;
        chk("latency_edges", 16'(k), 16'd8);
        first_bin = bin_out;
        first_err = err;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 16'(out_valid), 16'd1);
            chk("hold_bin", 16'(bin_out), 16'(first_bin));
            chk("hold_err", 16'(err), 16'(first_err));
            chk("hold_in_ready", 16'(in_ready), 16'd0);
        end
        chk("out_valid", 16'(out_valid), 16'd1);
        chk("err", 16'(err), 16'(exp_err));
        if (!ill) chk("bin_out", 16'(bin_out), 16'(exp_bin));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bcd_in    = 12'($urandom);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("release_valid", 16'(out_valid), 16'd0);
        chk("release_in_ready", 16'(in_ready), 16'd1);
        chk("release_bin_zero", 16'(bin_out), 16'd0);
    endtask

    initial begin
        logic [11:0] rb;
        bit          seen;
        total_checks  = 0;
        passed_checks = 0;
        failed_checks = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        bcd_in    = 12'h000;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_bin", 16'(bin_out), 16'd0);
        chk("rst_err", 16'(err), 16'd0);

        run_conv(12'h255, 0, 1'b0);
        run_conv(12'h128, 0, 1'b0);
        run_conv(12'h000, 0, 1'b0);
        run_conv(12'h099, 0, 1'b0);
        run_conv(12'h256, 0, 1'b0);
        run_conv(12'h2A0, 0, 1'b0);
        run_conv(12'h042, 5, 1'b0);
        run_conv(12'h187, 1, 1'b1);

        // Reset during the 4th SHIFT cycle discards the conversion.
        in_valid = 1'b1;
        bcd_in   = 12'h123;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 16'(in_ready), 16'd1);
        chk("midrst_out_valid", 16'(out_valid), 16'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_output", 16'(seen), 16'd0);
        run_conv(12'h010, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            rb[11:8] = 4'($urandom_range(0, 9));
            rb[7:4]  = 4'($urandom_range(0, 9));
            rb[3:0]  = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            run_conv(rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
